// File: rtl/ama_riscv_mmio_if.sv
// Core <-> MMIO strobe and read-back bundle.
// The core side is the master; the peripheral side is the slave.
interface ama_riscv_mmio_if;
    logic        store_to_uart;
    logic        load_from_uart;
    logic        inst_wb_nop_or_clear;
    logic        mmio_reset_cnt;
    logic [7:0]  mmio_uart_data_in;
    logic [31:0] mmio_instr_cnt;
    logic [31:0] mmio_cycle_cnt;
    logic [7:0]  mmio_uart_data_out;
    logic        mmio_data_out_valid;
    logic        mmio_data_in_ready;

    modport master (
        output store_to_uart, load_from_uart, inst_wb_nop_or_clear,
               mmio_reset_cnt, mmio_uart_data_in,
        input  mmio_instr_cnt, mmio_cycle_cnt, mmio_uart_data_out,
               mmio_data_out_valid, mmio_data_in_ready
    );

    modport slave (
        input  store_to_uart, load_from_uart, inst_wb_nop_or_clear,
               mmio_reset_cnt, mmio_uart_data_in,
        output mmio_instr_cnt, mmio_cycle_cnt, mmio_uart_data_out,
               mmio_data_out_valid, mmio_data_in_ready
    );
endinterface

// File: rtl/ama_riscv_mmio.sv
// MMIO peripheral: cycle / retired-instruction counters plus an 8N1 UART
// with a store-fed transmitter and a one-byte receive holding register.
module ama_riscv_mmio #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    ama_riscv_mmio_if.slave   bus,
    input  logic              uart_rx,
    output logic              uart_tx
);
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    uart_state_e   tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;
    logic          tx_ready;

    logic [1:0]    rx_sync_q;
    logic          rx_sync;
    uart_state_e   rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_data;
    logic          rx_valid;

    assign rx_sync = rx_sync_q[1];

    assign bus.mmio_cycle_cnt      = cycle_cnt;
    assign bus.mmio_instr_cnt      = instr_cnt;
    assign bus.mmio_uart_data_out  = rx_data;
    assign bus.mmio_data_out_valid = rx_valid;
    assign bus.mmio_data_in_ready  = tx_ready;

    // Counters; a counter-reset store wins over the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (bus.mmio_reset_cnt) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (!bus.inst_wb_nop_or_clear) instr_cnt <= instr_cnt + 32'd1;
        end
    end

    // Transmitter; ready is registered and high exactly while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_ready <= 1'b1;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (bus.store_to_uart) begin
                        tx_shift <= bus.mmio_uart_data_in;
                        tx_cnt   <= '0;
                        tx_ready <= 1'b0;
                        uart_tx  <= 1'b0;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        uart_tx  <= tx_shift[0];
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_idx   <= tx_idx + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            uart_tx  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_ready <= 1'b1;
                        tx_state <= IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous rx pin (idle high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_sync_q <= 2'b11;
        else     rx_sync_q <= {rx_sync_q[0], uart_rx};
    end

    // Receiver; a completing byte overrides a same-cycle load clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            if (bus.load_from_uart) rx_valid <= 1'b0;
            case (rx_state)
                IDLE: begin
                    if (!rx_sync) begin
                        rx_cnt   <= '0;
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_sync ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_idx == 3'd7) rx_state <= STOP;
                        else                rx_idx   <= rx_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                        // A low stop bit is a framing error: drop the byte.
                        if (rx_sync) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ama_riscv_mmio.md
# ama_riscv_mmio

Memory-mapped I/O peripheral for the core top, directly downstream of it. It consumes the core's MMIO strobes and produces the MMIO read values the core muxes into loads. It holds the 32-bit cycle and retired-instruction counters and a full-duplex 8N1 UART: a transmit serializer fed by core stores and a receive deserializer with a one-byte holding register read by core loads.

## Interface
- CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- store_to_uart  in  1  core store to the UART TX data address this cycle.
- load_from_uart  in  1  core load from the UART RX data address this cycle.
- inst_wb_nop_or_clear  in  1  high when the writeback slot holds a bubble or flushed instruction.
- mmio_reset_cnt  in  1  core store to the counter-reset address this cycle.
- mmio_uart_data_in  in  8  byte to transmit; valid with store_to_uart.
- uart_rx  in  1  serial input pin, asynchronous, idle high.
- mmio_instr_cnt  out  32  retired-instruction counter.
- mmio_cycle_cnt  out  32  cycle counter.
- mmio_uart_data_out  out  8  last received byte.
- mmio_data_out_valid  out  1  RX holding register full.
- mmio_data_in_ready  out  1  TX idle; a store is accepted.
- uart_tx  out  1  serial output pin, idle high.

## Operation
- Reset values: both counters 0, mmio_uart_data_out 0x00, mmio_data_out_valid 0, mmio_data_in_ready 1, uart_tx 1, RX/TX FSMs IDLE, both rx synchronizer flops 1.
- Cycle counter: +1 every cycle. Instr counter: +1 when inst_wb_nop_or_clear = 0. Both wrap 0xFFFF_FFFF -> 0.
- mmio_reset_cnt = 1: both counters load 0 that edge, overriding increment.
- TX FSM IDLE -> START -> DATA -> STOP -> IDLE. Bit-period counter runs 0..CLKS_PER_BIT-1; 3-bit index counts data bits.
- IDLE: store_to_uart && mmio_data_in_ready latches the byte and enters START. store_to_uart while not ready is dropped silently; software polls ready.
- Line levels: START drives 0, DATA drives byte LSB first, STOP drives 1, each for CLKS_PER_BIT cycles. mmio_data_in_ready = (state == IDLE).
- RX input passes through a 2-flop synchronizer; the FSM uses only the synchronized value.
- RX FSM IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: synchronized rx = 0 enters START and clears the bit counter.
  - START: at count CLKS_PER_BIT/2 - 1 (mid-bit), rx still 0 enters DATA; rx = 1 is a glitch and returns to IDLE.
  - DATA: sample once per CLKS_PER_BIT thereafter, shifting LSB first; after 8 samples enter STOP.
  - STOP: sample one bit later. Value 1 writes the byte to mmio_uart_data_out and sets valid. Value 0 is a framing error: byte discarded, valid and data unchanged. Either way return to IDLE.
- load_from_uart clears mmio_data_out_valid. Data is left unchanged; the core reads it combinationally the same cycle.
- Simultaneous load_from_uart and RX byte completion: the new byte is written and valid stays 1.
- Overrun: a new byte overwrites an unread one; valid stays 1; no error flag.
- Reset mid-frame: both FSMs abort to IDLE and uart_tx returns to 1 immediately (asynchronous).

## Timing
- Counters are registered; an event at edge N is visible after edge N.
- TX: store accepted at edge N. Ready is low and uart_tx = 0 from edge N+1. Frame lasts exactly 10*CLKS_PER_BIT cycles. Ready returns high at edge N+1+10*CLKS_PER_BIT, and a back-to-back store is accepted that same cycle.
- RX: valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the falling start edge on uart_rx, ±1 cycle for synchronizer phase.
- No combinational paths from inputs to outputs.

## Test plan
- Reset, then 100 cycles with inst_wb_nop_or_clear toggling every cycle -> cycle_cnt = 100, instr_cnt = 50. Assert mmio_reset_cnt for one cycle -> both read 0 next cycle, then resume counting.
- Force cycle_cnt to 0xFFFF_FFFE, run 3 cycles -> reads 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001.
- CLKS_PER_BIT = 8; store 0xA5 -> uart_tx shows 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; ready low for exactly 80 cycles. A second store during the frame is dropped.
- Loop uart_tx to uart_rx, send 0x3C -> data_out = 0x3C, valid = 1. Assert load_from_uart -> valid = 0 next cycle.
- Drive an rx frame 0x55 with stop bit 0 -> valid stays 0 and data_out unchanged. Drive a 3-cycle low glitch -> FSM returns to IDLE and no byte is produced.
- Receive 0x11, leave it unread, then receive 0x22 with load_from_uart on its completion cycle -> data_out = 0x22, valid = 1. Assert rst mid-TX-frame -> uart_tx = 1 and ready = 1 asynchronously.
